// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin owner of the single rgmii_tx transmit path.
// A winning source gets its destination MAC and ethertype latched, sees
// send_next as its enable, and has its nibbles registered onto mac_phy_txd.
// Once its frame ends or times out, a fixed inter-frame gap runs before the
// next grant.
module tx_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int IFG_CYCLES = 12,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [48*NUM_REQ-1:0]   req_dest,
    input  logic [16*NUM_REQ-1:0]   req_ethertype,
    input  logic [NUM_REQ-1:0]      src_ovalid,
    input  logic [4*NUM_REQ-1:0]    src_dout,
    output logic [NUM_REQ-1:0]      src_en,
    output logic [NUM_REQ-1:0]      grant,
    input  logic                    send_next,
    output logic                    mac_phy_txen,
    output logic [3:0]              mac_phy_txd,
    output logic [47:0]             mac_dest,
    output logic [15:0]             ethertype,
    output logic                    done,
    output logic                    abort,
    output logic                    busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q;
    logic [IW-1:0]       gidx_q;
    logic [IW-1:0]       last_q;
    logic [47:0]         dest_q;
    logic [15:0]         et_q;
    logic                txen_q;
    logic [3:0]          txd_q;
    logic                done_q;
    logic                abort_q;
    logic                seen_q;
    logic [TW-1:0]       tmo_cnt_q;
    logic [GW-1:0]       gap_cnt_q;

    // Per-source views of the flattened input buses.
    logic [47:0] dest_arr [NUM_REQ];
    logic [15:0] et_arr   [NUM_REQ];
    logic [3:0]  dout_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign dest_arr[gi] = req_dest[48*gi +: 48];
            assign et_arr[gi]   = req_ethertype[16*gi +: 16];
            assign dout_arr[gi] = src_dout[4*gi +: 4];
        end
    endgenerate

    // Round-robin pick: first pending request after the last winner.
    logic [IW-1:0] win_idx;
    logic          win_found;
    int            scan_idx;
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_q) + k) % NUM_REQ;
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_idx);
            end
        end
    end

    // Frame-level events for the granted source.
    logic g_ovalid;
    logic accept;
    logic eof;
    logic tmo;
    logic gap_end;
    always_comb begin
        g_ovalid = src_ovalid[gidx_q];
        accept   = (state_q == ST_SEND) && send_next && g_ovalid;
        eof      = (state_q == ST_SEND) && seen_q && send_next && !g_ovalid;
        // A nibble arriving on the deadline edge still counts as on time.
        tmo      = (state_q == ST_SEND) && !seen_q && !accept &&
                   (tmo_cnt_q >= TW'(TIMEOUT - 1));
        gap_end  = (state_q == ST_GAP) && (gap_cnt_q >= GW'(IFG_CYCLES - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (win_found)   state_d = ST_SEND;
            ST_SEND: if (eof || tmo)  state_d = ST_GAP;
            ST_GAP:  if (gap_end)     state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Output logic: enable is send_next steered to the owner, no extra latency.
    always_comb begin
        busy         = (state_q != ST_IDLE);
        src_en       = grant_q & {NUM_REQ{send_next}};
        grant        = grant_q;
        mac_phy_txen = txen_q;
        mac_phy_txd  = txd_q;
        mac_dest     = dest_q;
        ethertype    = et_q;
        done         = done_q;
        abort        = abort_q;
    end

    // Datapath: grant latch, nibble register, timeout and gap counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q   <= '0;
            gidx_q    <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            dest_q    <= '0;
            et_q      <= '0;
            txen_q    <= 1'b0;
            txd_q     <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            seen_q    <= 1'b0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        grant_q   <= NUM_REQ'(1) << win_idx;
                        gidx_q    <= win_idx;
                        last_q    <= win_idx;
                        dest_q    <= dest_arr[win_idx];
                        et_q      <= et_arr[win_idx];
                        txen_q    <= 1'b1;
                        seen_q    <= 1'b0;
                        tmo_cnt_q <= '0;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        txd_q  <= dout_arr[gidx_q];
                        seen_q <= 1'b1;
                    end
                    if (!seen_q && (tmo_cnt_q != TW'(TIMEOUT))) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                    if (eof || tmo) begin
                        grant_q   <= '0;
                        txen_q    <= 1'b0;
                        txd_q     <= '0;
                        done_q    <= eof;
                        abort_q   <= tmo;
                        gap_cnt_q <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q != GW'(IFG_CYCLES)) begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: a frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tx_arbiter;

    localparam int N   = 2;
    localparam int IFG = 12;
    localparam int TO  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [48*N-1:0]   req_dest;
    logic [16*N-1:0]   req_ethertype;
    logic [N-1:0]      src_ovalid;
    logic [4*N-1:0]    src_dout;
    logic [N-1:0]      src_en;
    logic [N-1:0]      grant;
    logic              send_next;
    logic              mac_phy_txen;
    logic [3:0]        mac_phy_txd;
    logic [47:0]       mac_dest;
    logic [15:0]       ethertype;
    logic              done;
    logic              abort;
    logic              busy;

    tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_dest(req_dest),
        .req_ethertype(req_ethertype), .src_ovalid(src_ovalid),
        .src_dout(src_dout), .src_en(src_en), .grant(grant),
        .send_next(send_next), .mac_phy_txen(mac_phy_txen),
        .mac_phy_txd(mac_phy_txd), .mac_dest(mac_dest),
        .ethertype(ethertype), .done(done), .abort(abort), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (frame-level) ----------------
    int          ph;          // 0 idle, 1 sending, 2 inter-frame gap
    logic [N-1:0] m_grant;
    int          m_g, m_last, m_since, m_gap, w;
    logic [47:0] m_dest;
    logic [15:0] m_et;
    logic        m_txen, m_done, m_abort, m_seen, found;
    logic [3:0]  m_txd;
    bit          mvalid = 1'b0;

    always begin
        @(posedge clk);
        if (!rst) begin
            ph = 0; m_grant = '0; m_txen = 0; m_txd = '0; m_dest = '0; m_et = '0;
            m_done = 0; m_abort = 0; m_last = N - 1; m_seen = 0; mvalid = 1'b1;
        end else if (mvalid) begin
            m_done = 0; m_abort = 0;
            if (ph == 0) begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    w = (m_last + k) % N;
                    if (!found && req[w]) begin found = 1; m_g = w; end
                end
                if (found) begin
                    m_grant = '0; m_grant[m_g] = 1'b1;
                    m_dest = req_dest[48*m_g +: 48];
                    m_et = req_ethertype[16*m_g +: 16];
                    m_txen = 1; m_last = m_g; m_since = 0; m_seen = 0; ph = 1;
                end
            end else if (ph == 1) begin
                if (m_seen && send_next && !src_ovalid[m_g]) begin
                    m_grant = '0; m_txen = 0; m_txd = '0; m_done = 1; ph = 2; m_gap = 0;
                end else if (send_next && src_ovalid[m_g]) begin
                    m_txd = src_dout[4*m_g +: 4]; m_seen = 1;
                end else if (!m_seen) begin
                    m_since++;
                    if (m_since >= TO) begin
                        m_grant = '0; m_txen = 0; m_txd = '0; m_abort = 1; ph = 2; m_gap = 0;
                    end
                end
            end else begin
                m_gap++;
                if (m_gap >= IFG) ph = 0;
            end
        end
        #1;
        if (mvalid) begin
            chk("cmp_grant", 64'(grant), 64'(m_grant));
            chk("cmp_src_en", 64'(src_en), 64'(m_grant & {N{send_next}}));
            chk("cmp_txen", 64'(mac_phy_txen), 64'(m_txen));
            chk("cmp_txd", 64'(mac_phy_txd), 64'(m_txd));
            chk("cmp_dest", 64'(mac_dest), 64'(m_dest));
            chk("cmp_ethertype", 64'(ethertype), 64'(m_et));
            chk("cmp_done", 64'(done), 64'(m_done));
            chk("cmp_abort", 64'(abort), 64'(m_abort));
            chk("cmp_busy", 64'(busy), 64'(ph != 0));
            chk("inv_onehot", 64'($onehot0(grant)), 64'(1));
            chk("inv_done_abort", 64'(done && abort), 64'(0));
        end
    end

    // ---------------- source emulation ----------------
    logic [3:0]  base [N];
    int          nlen [N];
    int          nidx [N];
    logic [N-1:0] cons_snap;
    int          cyc = 0;

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            src_ovalid[i] = grant[i] && (nidx[i] < nlen[i]);
            src_dout[4*i +: 4] = base[i] + 4'(nidx[i]);
        end
    endtask

    // One clock: note what the next edge will consume, advance, redrive sources.
    task automatic tick();
        for (int i = 0; i < N; i++) cons_snap[i] = grant[i] && send_next && src_ovalid[i];
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (!grant[i]) nidx[i] = 0;
            else if (cons_snap[i]) nidx[i]++;
        end
        drive_src();
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 200 && busy; c++) tick();
        chk(name, 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bc, dc, gc, ng;
        bit got, gotg, hit;
        logic [N-1:0] pg;
        logic [N-1:0] gseq [4];
        rst = 0; req = '0; req_dest = '0; req_ethertype = '0; send_next = 0;
        src_ovalid = '0; src_dout = '0; cons_snap = '0;
        for (int i = 0; i < N; i++) begin base[i] = '0; nlen[i] = 0; nidx[i] = 0; end
        tick(); tick();
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_txen", 64'(mac_phy_txen), 64'(0));
        chk("rst_dest", 64'(mac_dest), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst = 1;

        // Single frame from source 0, nibbles 1..8.
        req_dest[47:0] = 48'hFFFF_FFFF_FFFF; req_ethertype[15:0] = 16'h0806;
        base[0] = 4'd1; nlen[0] = 8; send_next = 1; req = 2'b01;
        tick();
        chk("t1_grant", 64'(grant), 64'(2'b01));
        chk("t1_txen", 64'(mac_phy_txen), 64'(1));
        chk("t1_dest", 64'(mac_dest), 64'(48'hFFFF_FFFF_FFFF));
        chk("t1_ethertype", 64'(ethertype), 64'(16'h0806));
        req = 2'b00;
        k = 1; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (cons_snap[0]) begin chk("t1_nibble", 64'(mac_phy_txd), 64'(k)); k++; end
            if (done) got = 1;
        end
        chk("t1_done_seen", 64'(got), 64'(1));
        chk("t1_nibble_count", 64'(k), 64'(9));
        chk("t1_txen_drop", 64'(mac_phy_txen), 64'(0));
        bc = busy ? 1 : 0; dc = 0;
        for (int c = 0; c < IFG + 4; c++) begin
            tick();
            if (busy) bc++;
            if (done) dc++;
        end
        chk("t1_busy_gap", 64'(bc), 64'(IFG));
        chk("t1_done_once", 64'(dc), 64'(0));

        // Round-robin with both sources requesting, send_next throttled.
        rst = 0; tick(); rst = 1;
        req_dest[95:48] = 48'h0200_0000_0001; req_ethertype[31:16] = 16'h0800;
        base[0] = 4'd2; nlen[0] = 3; base[1] = 4'd10; nlen[1] = 3;
        req = 2'b11; ng = 0; pg = '0; dc = 0;
        for (int i = 0; i < 4; i++) gseq[i] = '0;
        for (int c = 0; c < 400 && ng < 4; c++) begin
            send_next = (c % 3 != 2);
            tick();
            if (done) dc = cyc;
            if (grant != 0 && pg == 0) begin
                gseq[ng] = grant;
                if (ng > 0) chk("t2_gap_to_grant", 64'(cyc - dc), 64'(IFG + 1));
                ng++;
            end
            pg = grant;
        end
        chk("t2_frames", 64'(ng), 64'(4));
        chk("t2_grant0", 64'(gseq[0]), 64'(2'b01));
        chk("t2_grant1", 64'(gseq[1]), 64'(2'b10));
        chk("t2_grant2", 64'(gseq[2]), 64'(2'b01));
        chk("t2_grant3", 64'(gseq[3]), 64'(2'b10));
        req = 2'b00; send_next = 1;
        wait_idle("t2_idle");

        // Timeout: source 1 granted, never presents a nibble.
        nlen[1] = 0; req = 2'b10;
        tick();
        chk("t3_grant", 64'(grant), 64'(2'b10));
        gc = cyc; req = 2'b00; got = 0; dc = 0; k = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            if (done) dc++;
            if (abort) begin got = 1; k = cyc; end
        end
        chk("t3_abort_seen", 64'(got), 64'(1));
        chk("t3_abort_latency", 64'(k - gc), 64'(TO));
        chk("t3_no_done", 64'(dc), 64'(0));
        chk("t3_grant_clear", 64'(grant), 64'(0));
        wait_idle("t3_idle");

        // Source 1 requests while source 0 is mid-frame.
        req_dest[47:0] = 48'hA1A2_A3A4_A5A6; req_ethertype[15:0] = 16'h0800;
        base[0] = 4'd3; nlen[0] = 6; req = 2'b01;
        tick();
        chk("t4_grant0", 64'(grant), 64'(2'b01));
        req = 2'b00;
        tick(); tick();
        req_dest[95:48] = 48'hB1B2_B3B4_B5B6; req_ethertype[31:16] = 16'h86DD;
        base[1] = 4'd5; nlen[1] = 2; req = 2'b10;
        req_dest[47:0] = 48'h0;
        got = 0; dc = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            chk("t4_dest_hold", 64'(mac_dest), 64'(48'hA1A2_A3A4_A5A6));
            if (done) begin got = 1; dc = cyc; end
        end
        chk("t4_done_seen", 64'(got), 64'(1));
        gotg = 0; gc = 0;
        for (int c = 0; c < 40 && !gotg; c++) begin
            tick();
            if (grant != 0) begin gotg = 1; gc = cyc; end
        end
        chk("t4_grant1", 64'(grant), 64'(2'b10));
        chk("t4_grant_delay", 64'(gc - dc), 64'(IFG + 1));
        chk("t4_dest1", 64'(mac_dest), 64'(48'hB1B2_B3B4_B5B6));
        chk("t4_ethertype1", 64'(ethertype), 64'(16'h86DD));
        req = 2'b00;
        wait_idle("t4_idle");

        // Reset during nibble 4 with both sources pending.
        req_dest[47:0] = 48'h0011_2233_4455;
        base[0] = 4'd1; nlen[0] = 8; req = 2'b11;
        tick();
        chk("t5_grant", 64'(grant), 64'(2'b01));
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            tick();
            if (src_ovalid[0] && src_dout[3:0] == 4'd4) hit = 1;
        end
        chk("t5_reached_nibble4", 64'(hit), 64'(1));
        rst = 0;
        tick();
        chk("t5_rst_grant", 64'(grant), 64'(0));
        chk("t5_rst_src_en", 64'(src_en), 64'(0));
        chk("t5_rst_txen", 64'(mac_phy_txen), 64'(0));
        chk("t5_rst_txd", 64'(mac_phy_txd), 64'(0));
        chk("t5_rst_dest", 64'(mac_dest), 64'(0));
        chk("t5_rst_ethertype", 64'(ethertype), 64'(0));
        chk("t5_rst_done_abort", 64'({done, abort}), 64'(0));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        rst = 1;
        tick();
        chk("t5_first_grant", 64'(grant), 64'(2'b01));
        req = 2'b00;
        wait_idle("t5_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
